// File: rtl/pieo_sched_pkg.sv
// pieo_sched_pkg: shared FSM states and element layout {time, rank, id} for PIEO dequeue schedulers.
// Contents: state_t (IDLE/ISSUE/WAIT_END), field offsets (ID_LSB, rank_lsb, time_lsb), make_elem composer.
package pieo_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END} state_t;
    localparam int ID_LSB = 0;
    function automatic int rank_lsb(input int id_w);
        return ID_LSB + id_w;
    endfunction
    function automatic int time_lsb(input int id_w, input int rank_w);
        return rank_lsb(id_w) + rank_w;
    endfunction
    // Callers cast the result down to their element width.
    function automatic logic [31:0] make_elem(input int id_w, input int rank_w,
                                              input logic [31:0] t, input logic [31:0] r,
                                              input logic [31:0] id);
        return (t << time_lsb(id_w, rank_w)) | (r << rank_lsb(id_w)) | (id << ID_LSB);
    endfunction
endpackage

// File: rtl/pieo_rr_deq_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at index >= base, wrapping.
// Ports: req_i (request vector), base_i (start index), win_o (winner id), found_o (any request).
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] base_i,
    output logic [W-1:0] win_o,
    output logic         found_o
);
    logic [2*N-1:0] req2;
    assign req2 = {req_i, req_i};
    // Upper copy is always unmasked, so wrap-around works for any N; scanning downward leaves the lowest hit.
    always_comb begin
        win_o = '0;
        found_o = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (req2[j] && j >= int'(base_i)) begin
                win_o = W'(j >= N ? j - N : j);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pieo_rr_deq_scheduler.sv
// pieo_rr_deq_scheduler: work-conserving round-robin grant of one queue at a time to the post-dequeue stage.
// Ports: clk, rst (async active-high), en_in, fifo_backlog, tb_fifo_eligible, post_deq_ready, post_deq_end -> deq_valid, deq_element {time,rank,id}, busy, active_id.
// Option: PIEO_STRICT_PRIO_EN selects lowest-index-wins arbitration and rank = min(id, 2^RANK_LOG-1).
module pieo_rr_deq_scheduler
    import pieo_sched_pkg::*;
#(
    parameter int NUM_QUEUES = 3,
    parameter int ID_LOG     = $clog2(NUM_QUEUES),
    parameter int RANK_LOG   = 1,
    parameter int TIME_LOG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_in,
    input  logic [NUM_QUEUES-1:0]          fifo_backlog,
    input  logic [NUM_QUEUES-1:0]          tb_fifo_eligible,
    input  logic                           post_deq_ready,
    input  logic [NUM_QUEUES-1:0]          post_deq_end,
    output logic                           deq_valid,
    output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] deq_element,
    output logic                           busy,
    output logic [ID_LOG-1:0]              active_id
);
    localparam int EW = ID_LOG + RANK_LOG + TIME_LOG;
    localparam logic [31:0] RMAX = (32'd1 << RANK_LOG) - 32'd1;
    state_t state_q, state_d;
    logic [ID_LOG-1:0] rr_ptr_q, rr_ptr_d, active_id_q, active_id_d, pick_id, base;
    logic [EW-1:0] elem_q, elem_d;
    logic [NUM_QUEUES-1:0] req;
    logic [31:0] rank;
    logic pick_found, end_hit;
    assign req = fifo_backlog & tb_fifo_eligible;
`ifdef PIEO_STRICT_PRIO_EN
    assign base = '0;
    assign rank = 32'(pick_id) > RMAX ? RMAX : 32'(pick_id);
`else
    assign base = rr_ptr_q;
    assign rank = '0;
`endif
    rr_pick #(.N(NUM_QUEUES), .W(ID_LOG)) u_pick (
        .req_i(req), .base_i(base), .win_o(pick_id), .found_o(pick_found)
    );
    // Only the completion pulse of the outstanding queue ends the grant.
    assign end_hit = |(post_deq_end & (NUM_QUEUES'(1) << active_id_q));
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        active_id_d = active_id_q;
        elem_d = elem_q;
        case (state_q)
            IDLE: if (en_in && post_deq_ready && pick_found) begin
                state_d = ISSUE;
                active_id_d = pick_id;
                elem_d = EW'(make_elem(ID_LOG, RANK_LOG, 32'd0, rank, 32'(pick_id)));
            end
            ISSUE: state_d = post_deq_ready ? WAIT_END : ISSUE;
            WAIT_END: if (end_hit) begin
                state_d = IDLE;
                rr_ptr_d = (32'(active_id_q) == 32'(NUM_QUEUES - 1)) ? '0 : active_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            active_id_q <= '0;
            elem_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            active_id_q <= active_id_d;
            elem_q <= elem_d;
        end
    end
    assign deq_valid = state_q == ISSUE;
    assign busy = state_q != IDLE;
    assign deq_element = elem_q;
    assign active_id = active_id_q;
endmodule
